// File: rtl/uart_param_shifter.sv
// Parametrised UART data shifter: one shift engine shared by TX (PISO) and
// RX (SIPO), paced by a baud-tick strobe, with running parity for the framer.
module uart_param_shifter #(
  parameter int unsigned MAX_WIDTH = 8,
  parameter int unsigned LEN_W     = $clog2(MAX_WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 start,
  input  logic                 en,
  input  logic                 mode,
  input  logic                 msb_first,
  input  logic [LEN_W-1:0]     len,
  input  logic [MAX_WIDTH-1:0] data_in,
  input  logic                 serial_in,
  output logic                 serial_out,
  output logic [MAX_WIDTH-1:0] data_out,
  output logic                 parity,
  output logic                 shift_en,
  output logic [LEN_W-1:0]     shift_cnt,
  output logic                 done
);

  localparam int unsigned      IDX_W   = $clog2(MAX_WIDTH);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WIDTH);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state_q, state_d;
  logic                 mode_q;
  logic                 msb_q;
  logic [LEN_W-1:0]     len_q;
  logic [MAX_WIDTH-1:0] data_q;
  logic [MAX_WIDTH-1:0] shadow_q;

  logic [LEN_W-1:0]     len_clamped;
  logic [IDX_W-1:0]     bit_idx;
  logic                 last_bit;
  logic                 tx_bit;
  logic                 in_bit;
  logic [MAX_WIDTH-1:0] shadow_d;
  logic [MAX_WIDTH-1:0] len_mask;

  // Bit selection, clamped length and the RX shadow update for this tick
  always_comb begin
    len_clamped = ((len == '0) || (len > MAX_LEN)) ? MAX_LEN : len;
    bit_idx     = msb_q ? IDX_W'(len_q - ONE - shift_cnt) : IDX_W'(shift_cnt);
    last_bit    = (shift_cnt == (len_q - ONE));
    tx_bit      = data_q[bit_idx];
    in_bit      = mode_q ? serial_in : tx_bit;
    shadow_d    = shadow_q;
    shadow_d[bit_idx] = serial_in;
    // Shifting all-ones left by len leaves zeros in the low len bits; a full
    // MAX_WIDTH shift clears everything, so the inverse keeps the whole word.
    len_mask    = ~({MAX_WIDTH{1'b1}} << len_q);
  end

  // State register
  always_ff @(posedge clk) begin
    if (srst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (en && last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame configuration latch, shift counter, parity and RX word capture
  always_ff @(posedge clk) begin
    if (srst) begin
      mode_q    <= 1'b0;
      msb_q     <= 1'b0;
      len_q     <= '0;
      data_q    <= '0;
      shadow_q  <= '0;
      data_out  <= '0;
      parity    <= 1'b0;
      shift_en  <= 1'b0;
      shift_cnt <= '0;
      done      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mode_q    <= mode;
            msb_q     <= msb_first;
            len_q     <= len_clamped;
            data_q    <= data_in;
            shadow_q  <= '0;
            parity    <= 1'b0;
            shift_cnt <= '0;
            shift_en  <= 1'b1;
          end
        end
        SHIFT: begin
          if (en) begin
            parity    <= parity ^ in_bit;
            shift_cnt <= shift_cnt + ONE;
            if (mode_q) shadow_q <= shadow_d;
            if (last_bit) begin
              shift_en <= 1'b0;
              done     <= 1'b1;
              if (mode_q) data_out <= shadow_d & len_mask;
            end
          end
        end
        DONE: begin
          done      <= 1'b0;
          shift_cnt <= '0;
        end
        default: begin
          done      <= 1'b0;
          shift_en  <= 1'b0;
          shift_cnt <= '0;
        end
      endcase
    end
  end

  assign serial_out = ((state_q == SHIFT) && !mode_q) ? tx_bit : 1'b1;

endmodule

// File: doc/uart_param_shifter.md
Name: uart_param_shifter

Overview:
- Parametrised successor to the fixed-depth UART data shifter.
- Single shift engine for both directions: TX mode is parallel-in/serial-out, RX mode is serial-in/parallel-out.
- Frame length, bit order and mode are selectable per frame. Shifting is paced by an external baud-tick strobe (`en`).
- Sits between the UART TX/RX framers and the baud generator; computes running parity for the framer.

Parameters:
- MAX_WIDTH, 8, maximum data bits per frame (≥2).
- LEN_W, $clog2(MAX_WIDTH)+1, width of `len` and `shift_cnt`.

Ports:
- clk  in  1  rising-edge clock
- srst  in  1  synchronous reset, active-high
- start  in  1  frame request; sampled in IDLE only
- en  in  1  shift strobe (baud tick); one bit per cycle with en=1 in SHIFT
- mode  in  1  0=TX (PISO), 1=RX (SIPO); latched at start
- msb_first  in  1  0=LSB first, 1=MSB first; latched at start
- len  in  LEN_W  bits per frame; latched at start
- data_in  in  MAX_WIDTH  TX parallel word; latched at start
- serial_in  in  1  RX serial bit
- serial_out  out  1  TX serial bit
- data_out  out  MAX_WIDTH  RX word, right-aligned
- parity  out  1  XOR of all frame bits
- shift_en  out  1  high while in SHIFT (busy)
- shift_cnt  out  LEN_W  bits shifted so far in current frame
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: synchronous, active-high, on `clk` only; no asynchronous reset path.
  - State → IDLE.
  - shift_en=0, done=0, shift_cnt=0, data_out=0, parity=0.
  - serial_out=1 (line idle high).
  - All latched config cleared.
- Reset mid-frame aborts the frame immediately: no done pulse, data_out=0.
- len clamp: len=0 or len>MAX_WIDTH is treated as MAX_WIDTH (the clamped value is latched).
- FSM states IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge k → at edge k: latch mode, msb_first, clamped len and data_in; shift_cnt=0; parity=0; shift_en=1; state=SHIFT.
  - start is level-sampled; it is not edge-detected.
- SHIFT:
  - Each edge with en=1: process bit index b, then shift_cnt++.
  - b = shift_cnt for LSB-first; b = len-1-shift_cnt for MSB-first.
  - Edges with en=0 hold all state.
  - Edge where en=1 and shift_cnt==len-1 → state=DONE, shift_en=0, done=1, shift_cnt=len.
  - Latency: done rises exactly len en-cycles after shift_en rose. With en tied high, that is len clocks.
- DONE: lasts one cycle, then → IDLE with done=0 and shift_cnt=0.
- start handling: ignored in SHIFT and DONE. A start held high through DONE is accepted in the next IDLE cycle, so the minimum inter-frame gap is 1 idle cycle.
- TX mode:
  - In SHIFT, serial_out = latched_data[b] combinationally from state, so bit b is present from the cycle shift_en rises.
  - parity ^= latched_data[b] on each en edge.
  - Outside SHIFT, serial_out=1.
  - data_out is not modified.
- RX mode:
  - On each en edge in SHIFT, serial_in is written to shadow[b] and parity ^= serial_in.
  - serial_out=1 throughout.
  - data_out updates only at the SHIFT→DONE edge: shadow bits [len-1:0], upper bits zeroed. It is stable otherwise.
- parity is valid from the done cycle and held until the next accepted start.
- Changes to config inputs during SHIFT have no effect.
- The block holds no X-sensitive state. All outputs are registered except serial_out, which is a mux of registers.

Test Plan:
- Reset, then TX, LSB-first, len=8, data_in=8'hA5, en=1 constant → serial_out sequence 1,0,1,0,0,1,0,1 during 8 shift_en cycles; done pulses 8 cycles after shift_en rises; parity=0.
- TX, MSB-first, len=5, data_in=8'h13, en high every 4th cycle → serial_out 1,0,0,1,1; each bit held for 4 clocks; shift_cnt reaches 5 at done; parity=1.
- RX, LSB-first, len=7, serial_in driving 7'h5A LSB first → data_out=8'h5A at the done cycle; data_out stable and unchanged before done; parity=0.
- len=0 and len=12 with MAX_WIDTH=8 → both run 8 bits; done 8 en-cycles after start.
- start pulsed during SHIFT and during DONE → ignored, no extra frame. start held high continuously → frames back-to-back with exactly one IDLE cycle between them.
- srst asserted mid-RX frame at shift_cnt=3 → next cycle shift_en=0, shift_cnt=0, data_out=0, serial_out=1, no done pulse. A subsequent start begins a clean frame.
